memory_responder: RTL

Single-port main-memory responder for the stack CPU: the memory side of the RD/WR/MFC handshake that the CPU controller initiates. It accepts a read or write request with the MAR address and MDR data, runs a configurable number of wait states, and then performs the access. It signals completion with a four-phase MFC acknowledge and drops MFC only after the controller withdraws its strobe. The block sits between the datapath's MAR/MDR and the memory array, which it contains.

---
 rtl/memory_responder_if.sv | 23 ++
 rtl/memory_responder.sv | 119 +++++++++++
 2 files changed

// File: rtl/memory_responder_if.sv
// RD/WR/MFC handshake bus between the CPU controller (master) and the memory responder (slave).
interface memory_responder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  RD;
  logic                  WR;
  logic [15:0]           Address;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  MFC;
  logic                  Busy;
  logic                  ProtocolError;

  modport master (
    output RD, WR, Address, DataIn,
    input  DataOut, MFC, Busy, ProtocolError
  );

  modport slave (
    input  RD, WR, Address, DataIn,
    output DataOut, MFC, Busy, ProtocolError
  );
endinterface

// File: rtl/memory_responder.sv
// Main-memory responder: accepts RD/WR, inserts WAIT_CYCLES wait states, then
// performs the access and raises a four-phase MFC acknowledge.
module memory_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  memory_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

  state_t                state, state_nx;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  mfc;
  logic [DATA_WIDTH-1:0] dout;
  logic                  perr;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  logic                  req, req_both, strobe;
  logic                  busy, accept, enter_ack, acc_wr, mem_we;
  logic [ADDR_BITS-1:0]  acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  unused_addr_hi;

  assign req            = bus.RD ^ bus.WR;
  assign req_both       = bus.RD & bus.WR;
  // Only the strobe that started the access matters once it is latched.
  assign strobe         = op_wr ? bus.WR : bus.RD;
  assign unused_addr_hi = ^bus.Address[15:ADDR_BITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req) state_nx = NO_WAIT ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!strobe)          state_nx = S_IDLE;
        else if (cnt == 4'd0) state_nx = S_ACK;
      end
      S_ACK:   if (!strobe) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so the
  // access operands come straight from the bus while in IDLE.
  always_comb begin
    busy      = 1'b1;
    accept    = 1'b0;
    enter_ack = 1'b0;
    acc_wr    = op_wr;
    acc_addr  = addr_q;
    acc_data  = data_q;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        accept    = req;
        enter_ack = req & NO_WAIT;
        acc_wr    = bus.WR;
        acc_addr  = bus.Address[ADDR_BITS-1:0];
        acc_data  = bus.DataIn;
      end
      S_WAIT:  enter_ack = strobe & (cnt == 4'd0);
      default: ;
    endcase
  end

  assign mem_we = enter_ack & acc_wr & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      op_wr  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      mfc    <= 1'b0;
      dout   <= '0;
      perr   <= 1'b0;
    end else begin
      if (state == S_IDLE && req_both) perr <= 1'b1;
      if (accept) begin
        op_wr  <= bus.WR;
        addr_q <= bus.Address[ADDR_BITS-1:0];
        data_q <= bus.DataIn;
        cnt    <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_ack) begin
        mfc <= 1'b1;
        if (!acc_wr) dout <= mem[acc_addr];
      end else if (state == S_ACK && !strobe) begin
        mfc <= 1'b0;
      end
    end
  end

  // Array has no reset: contents survive reset and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_addr] <= acc_data;
  end

  assign bus.Busy          = busy;
  assign bus.MFC           = mfc;
  assign bus.DataOut       = dout;
  assign bus.ProtocolError = perr;
endmodule
